// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side endpoint for the cache's line refill and
// write-back port. It accepts one 128-bit line read or write at a time and
// answers with a single-cycle mem_ready pulse LATENCY cycles after acceptance.
// Line storage is held internally in an inferred RAM with a registered read.
// Optional feature macro: MEM_ACCESS_CNT_EN adds saturating rd_cnt/wr_cnt
// outputs that count completed (non-aborted) reads and writes.
module cache_mem_responder #(
  parameter int LATENCY = 4,   // 1..255
  parameter int ADDR_W  = 8,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              mem_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [27:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of BUSY cycles between acceptance and the response cycle.
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic                perr_q, perr_d;
  logic [LINE_W-1:0]   rdata_q;
  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  logic                rd_load;

  logic [LINE_W-1:0]   storage_q [2**ADDR_W];

  // Upper address bits alias onto the same lines; they are intentionally unused.
  generate
    if (ADDR_W < 28) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_addr[27:ADDR_W];
    end
  endgenerate

  // Reset asserts asynchronously and is released two clocks after mem_reset_n rises.
  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // State register and latched request.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, abort on a dropped request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_addr[ADDR_W-1:0];
          wdata_d = mem_wdata;
          op_wr_d = mem_write;          // write wins when both are raised
          if (mem_read && mem_write) perr_d = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 8'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (op_wr_q ? !mem_write : !mem_read) begin
          state_d = IDLE;
          cnt_d   = '0;
          perr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: the ready pulse is exactly the RESP state.
  always_comb begin
    mem_ready = (state_q == RESP);
    proto_err = perr_q;
    mem_rdata = rdata_q;
  end

  // RAM read is launched on the edge that enters RESP so data is valid during RESP.
  assign rd_load = (state_d == RESP) && !op_wr_d;

  // Registered read port; holds the last read line outside read responses.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   rdata_q <= '0;
    else if (rd_load) rdata_q <= storage_q[addr_d];
  end

  // Write port: commit the latched line at the end of a write response.
  always_ff @(posedge clk) begin
    if (state_q == RESP && op_wr_q) storage_q[addr_q] <= wdata_q;
  end

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Saturating counts of completed reads and writes.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (op_wr_q && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!op_wr_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
